// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one external divider among NUM_REQ requesters; one op in flight,
// turnaround 1 + 1 + divider latency + 1 cycles; req_ready only in IDLE, RESP holds until rsp_ready.
module divider_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DIVIDEND_BITS  = 5,
  parameter int DIVISOR_BITS   = 4,
  parameter int TIMEOUT_CYCLES = DIVIDEND_BITS + 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*DIVIDEND_BITS-1:0]  req_dividend,
  input  logic [NUM_REQ*DIVISOR_BITS-1:0]   req_divisor,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic [DIVIDEND_BITS-1:0]          rsp_quotient,
  output logic [DIVISOR_BITS-1:0]           rsp_remainder,
  output logic                              rsp_error,
  output logic                              rsp_timeout,
  output logic [DIVIDEND_BITS-1:0]          div_dividend,
  output logic [DIVISOR_BITS-1:0]           div_divisor,
  output logic                              div_start,
  input  logic [DIVIDEND_BITS-1:0]          div_quotient,
  input  logic [DIVISOR_BITS-1:0]           div_remainder,
  input  logic                              div_error,
  input  logic                              div_done,
  output logic                              busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [IDW-1:0]           r_ptr;
  logic [IDW-1:0]           r_id;
  logic [DIVIDEND_BITS-1:0] r_dividend;
  logic [DIVISOR_BITS-1:0]  r_divisor;
  logic [DIVIDEND_BITS-1:0] r_quot;
  logic [DIVISOR_BITS-1:0]  r_rem;
  logic                     r_err;
  logic                     r_tmo;
  logic [CW-1:0]            r_cnt;

  logic                     w_gnt_vld;
  logic [IDW-1:0]           w_gnt_idx;
  logic [DIVIDEND_BITS-1:0] w_sel_dividend;
  logic [DIVISOR_BITS-1:0]  w_sel_divisor;

  function automatic int rr_idx(input logic [IDW-1:0] ptr, input int k);
    return (int'(ptr) + k) % NUM_REQ;
  endfunction

  // Search starts just after the last winner so every requester is served in turn.
  always_comb begin
    w_gnt_vld      = 1'b0;
    w_gnt_idx      = '0;
    w_sel_dividend = '0;
    w_sel_divisor  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_gnt_vld && req_valid[rr_idx(r_ptr, k)]) begin
        w_gnt_vld      = 1'b1;
        w_gnt_idx      = IDW'(rr_idx(r_ptr, k));
        w_sel_dividend = req_dividend[rr_idx(r_ptr, k)*DIVIDEND_BITS +: DIVIDEND_BITS];
        w_sel_divisor  = req_divisor[rr_idx(r_ptr, k)*DIVISOR_BITS +: DIVISOR_BITS];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && r_state == S_IDLE && w_gnt_vld) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    div_start    = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b1;
    div_dividend = '0;
    div_divisor  = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_gnt_vld) begin
          w_next = (w_sel_divisor == '0) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_start    = 1'b1;
        div_dividend = r_dividend;
        div_divisor  = r_divisor;
        w_next       = S_WAIT;
      end
      S_WAIT: begin
        div_dividend = r_dividend;
        div_divisor  = r_divisor;
        if (div_done || r_cnt == CNT_LAST) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // div_done is only looked at in WAIT, so stale or abandoned completions fall through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= IDW'(NUM_REQ - 1);
      r_id       <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_err      <= 1'b0;
      r_tmo      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_ptr      <= w_gnt_idx;
            r_id       <= w_gnt_idx;
            r_dividend <= w_sel_dividend;
            r_divisor  <= w_sel_divisor;
            r_quot     <= '0;
            r_rem      <= '0;
            r_err      <= (w_sel_divisor == '0);
            r_tmo      <= 1'b0;
            r_cnt      <= '0;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (div_done) begin
            r_quot <= div_quotient;
            r_rem  <= div_remainder;
            r_err  <= div_error;
          end else if (r_cnt == CNT_LAST) begin
            r_err <= 1'b1;
            r_tmo <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_id        = r_id;
  assign rsp_quotient  = r_quot;
  assign rsp_remainder = r_rem;
  assign rsp_error     = r_err;
  assign rsp_timeout   = r_tmo;

endmodule

// File: tb/tb_divider_arbiter.sv
// Scoreboard bench for divider_arbiter with a behavioural divider of programmable latency.
module tb_divider_arbiter;
  localparam int NR = 4;
  localparam int DB = 5;
  localparam int VB = 4;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DB-1:0]  req_dividend;
  logic [NR*VB-1:0]  req_divisor;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [DB-1:0]     rsp_quotient;
  logic [VB-1:0]     rsp_remainder;
  logic              rsp_error;
  logic              rsp_timeout;
  logic [DB-1:0]     div_dividend;
  logic [VB-1:0]     div_divisor;
  logic              div_start;
  logic [DB-1:0]     div_quotient;
  logic [VB-1:0]     div_remainder;
  logic              div_error;
  logic              div_done;
  logic              busy;

  divider_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_start(div_start),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_error(div_error), .div_done(div_done),
    .busy(busy)
  );

  typedef struct {
    int id;
    int q;
    int r;
    int err;
    int tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_start  = 0;

  int   div_lat     = 1;
  int   div_hold    = 1;
  bit   div_hang    = 0;
  bit   div_stale   = 0;
  bit   div_err_inj = 0;
  logic [DB-1:0] m_a;
  logic [VB-1:0] m_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Response monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (div_start) n_start++;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp actual=id%0d required=none", rsp_id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_quotient", 32'(rsp_quotient), 32'(e.q));
        chk("rsp_remainder", 32'(rsp_remainder), 32'(e.r));
        chk("rsp_error", 32'(rsp_error), 32'(e.err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
      end
    end
  end

  // Behavioural divider: answers L cycles into WAIT and holds done for div_hold cycles.
  initial begin
    div_done = 1'b0; div_quotient = '0; div_remainder = '0; div_error = 1'b0;
    forever begin
      @(negedge clk);
      if (div_start && !div_hang) begin
        m_a = div_dividend;
        m_b = div_divisor;
        @(posedge clk); #1;
        div_done = 1'b0;
        for (int k = 1; k < div_lat; k++) begin @(posedge clk); #1; end
        if (busy) begin
          chk("div_dividend_held", 32'(div_dividend), 32'(m_a));
          chk("div_divisor_held", 32'(div_divisor), 32'(m_b));
        end
        div_quotient  = m_a / DB'(m_b);
        div_remainder = VB'(m_a % DB'(m_b));
        div_error     = div_err_inj;
        div_done      = 1'b1;
        for (int k = 0; k < div_hold; k++) begin @(posedge clk); #1; end
        div_done = 1'b0;
      end else if (div_stale) begin
        div_done = 1'b1; div_quotient = '1; div_remainder = '1; div_error = 1'b1;
      end else begin
        div_done = 1'b0;
      end
    end
  end

  task automatic set_op(input int i, input int a, input int b);
    req_dividend[i*DB +: DB] = DB'(a);
    req_divisor[i*VB +: VB]  = VB'(b);
  endtask

  // Waits for the grant, pushes the expected response, and measures negedges until rsp_valid.
  task automatic run(input int id, input int q, input int r, input int err, input int tmo,
                     input int lat, input bit hold);
    int   n;
    exp_t e;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == '0 && n < 20);
    chk("grant", 32'(req_ready), 32'(1) << id);
    if (req_ready == '0) return;
    e.id = id; e.q = q; e.r = r; e.err = err; e.tmo = tmo;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (!hold) req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
    chk("latency", 32'(n), 32'(lat));
    if (rsp_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    int s0;
    int n;
    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = '0; req_dividend = '0; req_divisor = '0;
    set_op(0, 10, 3); set_op(1, 17, 4); set_op(2, 23, 5); set_op(3, 31, 2);
    req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_div_start", 32'(div_start), 0);
    chk("rst_div_dividend", 32'(div_dividend), 0);
    chk("rst_div_divisor", 32'(div_divisor), 0);
    chk("rst_rsp_fields", {rsp_id, rsp_quotient, rsp_remainder, rsp_error, rsp_timeout}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // all four holding valid: grants 0,1,2,3,0
    run(0, 3, 1, 0, 0, 3, 1);
    run(1, 4, 1, 0, 0, 3, 1);
    run(2, 4, 3, 0, 0, 3, 1);
    run(3, 15, 1, 0, 0, 3, 1);
    run(0, 3, 1, 0, 0, 3, 0);

    req_valid = 4'b0100; s0 = n_start;
    run(2, 4, 3, 0, 0, 3, 0);
    chk("start_pulses_23_5", 32'(n_start - s0), 1);

    set_op(1, 17, 0); req_valid = 4'b0010; s0 = n_start;
    run(1, 0, 0, 1, 0, 1, 0);
    chk("start_pulses_div0", 32'(n_start - s0), 0);

    div_hang = 1; set_op(3, 20, 3); req_valid = 4'b1000;
    run(3, 0, 0, 1, 1, 11, 0);
    div_hang = 0;

    // done arrives on the last allowed WAIT cycle and must beat the timeout
    div_lat = 9; set_op(0, 30, 7); req_valid = 4'b0001;
    run(0, 4, 2, 0, 0, 11, 0);
    div_lat = 1;

    div_err_inj = 1; set_op(1, 9, 2); req_valid = 4'b0010;
    run(1, 4, 1, 1, 0, 3, 0);
    div_err_inj = 0;

    div_stale = 1; set_op(3, 31, 4); req_valid = 4'b1000;
    run(3, 7, 3, 0, 0, 3, 0);
    div_stale = 0;
    repeat (2) @(posedge clk); #1;

    div_lat = 2; div_hold = 3; set_op(0, 12, 3); req_valid = 4'b0001;
    run(0, 4, 0, 0, 0, 4, 0);
    div_lat = 1; div_hold = 1;
    repeat (3) @(posedge clk); #1;

    // response backpressure
    rsp_ready = 1'b0; set_op(1, 9, 4); req_valid = 4'b0010;
    run(1, 2, 1, 0, 0, 3, 0);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_fields", {rsp_id, rsp_quotient, rsp_remainder, rsp_error, rsp_timeout},
          {2'd1, 5'd2, 4'd1, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_at_accept", 32'(rsp_valid), 1);
    @(posedge clk); #1;
    chk("bp_idle_busy", 32'(busy), 0);
    chk("bp_idle_rsp_valid", 32'(rsp_valid), 0);

    // reset in the middle of WAIT; the late done must be ignored
    div_lat = 6; set_op(2, 20, 3); req_valid = 4'b0100;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == '0 && n < 20);
    chk("abandon_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk); #1;
    chk("abandon_busy_wait", 32'(busy), 1);
    rst_n = 1'b0; req_valid = 4'b1111;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    chk("midrst_div_start", 32'(div_start), 0);
    repeat (2) @(posedge clk); #1;
    req_valid = '0; rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    div_lat = 1;
    @(posedge clk); #1;
    set_op(0, 14, 4); req_valid = 4'b1111;
    run(0, 3, 2, 0, 0, 3, 0);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
